seq_stream_scanner: RTL
=======================

# seq_stream_scanner

Word-to-bit scheduler for the 1111/1101 sequence detector. It accepts parallel words over a valid/ready handshake and steps them MSB-first, one bit per clock, through an enable-gated detector FSM. It counts detections and reports one pulse per match. It sits between a word-oriented producer (switch bank, FIFO or bus register) and the status LEDs/counters.

## Interface
- WORD_W, 8, bits per input word (≥2)
- CNT_W, 8, width of the saturating match counter
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; all state cleared on the clock edge
- in_valid  in  1  producer has a word on in_data
- in_data  in  WORD_W  word to scan, MSB first
- in_ready  out  1  block can accept a word this cycle
- clear  in  1  synchronous: zeroes match_count and returns detector to S0
- busy  out  1  word currently being shifted
- word_done  out  1  high during the last shift cycle of a word
- match  out  1  one-cycle pulse per detected pattern
- match_count  out  CNT_W  saturating count of match pulses
- det_state  out  3  current detector state code (debug)

## Operation
- Scheduler FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, load in_data into the shift register, set bit_idx=WORD_W-1, and go to SHIFT.
  - SHIFT: each cycle, drive shreg[MSB] to the detector with step_en=1, shift left by 1, and decrement bit_idx. At bit_idx==0, word_done=1 and in_ready=1. On acceptance, reload and stay in SHIFT; otherwise go to IDLE.
- Detector FSM (advances only when step_en=1, otherwise holds). Codes S0..S6 = 0..6.
  - S0: 0→S0, 1→S1.
  - S1: 0→S0, 1→S2.
  - S2: 0→S4, 1→S3.
  - S3: 0→S4, 1→S5.
  - S4: 0→S0, 1→S6.
  - S5: 0→S4, 1→S5.
  - S6: 0→S0, 1→S2.
  - Codes 7+ go to S0.
- Detection: S5 = "1111", S6 = "1101". Overlap is allowed.
- match is registered: match <= step_en && (next state is S5 or S6). This includes the S5→S5 self-loop.
- Detector state persists across word boundaries; the bit stream is continuous.
- match_count increments on each match pulse and holds at 2^CNT_W-1.
- clear has priority over a coincident increment and over a coincident detector step.
  - On clear: count←0, detector←S0, and the match register←0 that cycle.
  - Shifting continues unaffected.
- in_data is sampled only at acceptance; changes while busy are ignored.

## Timing
- Acceptance edge = cycle 0. Bit i (i=1..WORD_W, MSB first) is stepped at the end of cycle i.
- match is high in cycle i+1 for a bit stepped in cycle i. match_count reflects it in cycle i+2.
- word_done and busy:
  - word_done is high in cycle WORD_W.
  - busy is high in cycles 1..WORD_W.
- Sustained throughput: one word per WORD_W cycles, with no gap when in_valid is held high.
- Reset state:
  - State: IDLE; detector S0; shreg=0; bit_idx=0.
  - Outputs: match=0, match_count=0, busy=0, word_done=0, det_state=0.
  - in_ready=0 while reset is high, 1 the cycle after.
- Reset mid-word aborts the word. The remaining bits are discarded and no match is produced for them.

## Structure
- Package seq_scan_pkg holds:
  - detector state localparams S0..S6 (3-bit);
  - scheduler states IDLE/SHIFT;
  - the debug state width.
- Sub-module seq_detect_core contains the detector FSM only. Its ports are clock, reset, clear, step_en, bit_in, match, state.
- Keep next-state logic, state register and output logic in separate always blocks.

## Test plan
- Reset, then send 8'hF0 → one match, in cycle 5; match_count=1 by cycle 6; word_done in cycle 8.
- Send 8'hFF from S0 → matches in cycles 5..9 (5 pulses); match_count=5.
- Send 8'hDD (11011101) from S0 → matches in cycles 5 and 9 (bits 4 and 8); match_count=2.
- Send 8'h03 then 8'hC0 back-to-back with in_valid held high → 16 consecutive busy cycles, no IDLE gap. The single match is on the 2nd bit of word 2 (cross-word), so match_count=1.
- With CNT_W=2, send 8'hFF → 5 match pulses, match_count saturates at 3. Then assert clear → count=0, det_state=0.
- Send 8'hFF, then assert reset in cycle 3 → next cycle busy=0, det_state=0, match_count=0. No match pulses follow, and in_ready=1 after reset is released.

Source files
------------

// File: rtl/seq_scan_pkg.sv
// Shared types for the word-to-bit sequence scanner: detector and scheduler
// state encodings plus the detection predicate.
package seq_scan_pkg;

  localparam int unsigned DET_W = 3;

  typedef enum logic [DET_W-1:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6
  } det_state_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sched_state_e;

  // S5 = "1111", S6 = "1101"
  function automatic logic is_detect(input det_state_e s);
    return (s == S5) || (s == S6);
  endfunction

endpackage

// File: rtl/seq_detect_core.sv
// Enable-gated 1111/1101 detector FSM with a registered one-cycle match pulse.
module seq_detect_core
  import seq_scan_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             step_en,
  input  logic             bit_in,
  output logic             match,
  output logic [DET_W-1:0] state
);

  det_state_e r_state;
  det_state_e w_next;
  logic       r_match;

  always_comb begin
    w_next = r_state;
    if (step_en) begin
      case (r_state)
        S0:      w_next = bit_in ? S1 : S0;
        S1:      w_next = bit_in ? S2 : S0;
        S2:      w_next = bit_in ? S3 : S4;
        S3:      w_next = bit_in ? S5 : S4;
        S4:      w_next = bit_in ? S6 : S0;
        S5:      w_next = bit_in ? S5 : S4;
        S6:      w_next = bit_in ? S2 : S0;
        default: w_next = S0;
      endcase
    end
  end

  // clear outranks a coincident step
  always_ff @(posedge clock) begin
    if (reset || clear) r_state <= S0;
    else                r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (reset || clear) r_match <= 1'b0;
    else                r_match <= step_en && is_detect(w_next);
  end

  assign match = r_match;
  assign state = r_state;

endmodule

// File: rtl/seq_stream_scanner.sv
// Accepts parallel words over valid/ready and steps them MSB-first, one bit
// per clock, into the sequence detector; counts matches with saturation.
module seq_stream_scanner
  import seq_scan_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  input  logic              clear,
  output logic              busy,
  output logic              word_done,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic [DET_W-1:0]  det_state
);

  localparam int unsigned IDX_W = $clog2(WORD_W);

  sched_state_e      r_sched;
  sched_state_e      w_sched_next;
  logic [WORD_W-1:0] r_shreg;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [CNT_W-1:0]  r_count;
  logic              w_last;
  logic              w_ready;
  logic              w_accept;
  logic              w_step;
  logic              w_match;

  assign w_last   = (r_sched == SHIFT) && (r_bit_idx == '0);
  assign w_ready  = !reset && ((r_sched == IDLE) || w_last);
  assign w_accept = in_valid && w_ready;
  assign w_step   = (r_sched == SHIFT);

  always_comb begin
    w_sched_next = r_sched;
    case (r_sched)
      IDLE:    if (w_accept) w_sched_next = SHIFT;
      SHIFT:   if (w_last)   w_sched_next = w_accept ? SHIFT : IDLE;
      default: w_sched_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_sched <= IDLE;
    else       r_sched <= w_sched_next;
  end

  // A reload on the last shift cycle overrides the shift, giving gapless words
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shreg   <= '0;
      r_bit_idx <= '0;
    end else if (w_accept) begin
      r_shreg   <= in_data;
      r_bit_idx <= IDX_W'(WORD_W - 1);
    end else if (r_sched == SHIFT) begin
      r_shreg <= r_shreg << 1;
      if (!w_last) r_bit_idx <= r_bit_idx - 1'b1;
    end
  end

  seq_detect_core u_core (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .step_en (w_step),
    .bit_in  (r_shreg[WORD_W-1]),
    .match   (w_match),
    .state   (det_state)
  );

  always_ff @(posedge clock) begin
    if (reset || clear)           r_count <= '0;
    else if (w_match && r_count != '1) r_count <= r_count + 1'b1;
  end

  assign in_ready    = w_ready;
  assign busy        = (r_sched == SHIFT);
  assign word_done   = w_last;
  assign match       = w_match;
  assign match_count = r_count;

endmodule
